ahb_slave_mem: RTL and testbench

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

---
 rtl/ahb_slave_mem_pkg.sv | 7 +
 rtl/ahb_lane_dec.sv | 18 +
 rtl/ahb_slave_mem.sv | 115 +++++++++++
 tb/tb_ahb_slave_mem.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ahb_slave_mem_pkg.sv
// Shared AHB encodings and the slave FSM state type.
package Definitions;
    typedef enum logic {OKAY = 1'b0, ERROR = 1'b1} Response_t;
    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} Trans_t;
    typedef enum logic [2:0] {BYTE = 3'b000, HALF = 3'b001, WORD = 3'b010} Size_t;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;
endpackage

// File: rtl/ahb_lane_dec.sv
// Byte-lane enable decode from transfer size and low address bits (little-endian).
module ahb_lane_dec
    import Definitions::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_i,
    output logic [3:0] lane_en_o
);
    always_comb begin
        lane_en_o = '0;
        case (hsize_i)
            BYTE:    lane_en_o = 4'b0001 << addr_i;
            HALF:    lane_en_o = addr_i[1] ? 4'b1100 : 4'b0011;
            WORD:    lane_en_o = 4'b1111;
            default: lane_en_o = '0;
        endcase
    end
endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite word memory slave with programmable wait states and two-cycle ERROR response.
module ahb_slave_mem
    import Definitions::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output Response_t   HRESP
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            write_q;
    logic [IW-1:0]   idx_q;
    logic [3:0]      lanes_q;
    logic [3:0]      lane_en;
    logic [31:0]     mem_q [DEPTH];

    logic accept, take, addr_err, complete;

    ahb_lane_dec u_lane_dec (
        .hsize_i   (HSIZE),
        .addr_i    (HADDR[1:0]),
        .lane_en_o (lane_en)
    );

    assign accept   = HSEL && HREADY && (HTRANS == NONSEQ || HTRANS == SEQ);
    assign take     = accept && (state_q == ST_IDLE);
    assign addr_err = ({2'b00, HADDR[31:2]} >= 32'(DEPTH))
                   || (HSIZE > WORD)
                   || (HSIZE == HALF && HADDR[0])
                   || (HSIZE == WORD && HADDR[1:0] != 2'b00);
    // ST_IDLE with a pending data phase is the completion cycle.
    assign complete = (state_q == ST_IDLE) && pend_q;
    assign HRDATA   = (complete && !write_q) ? mem_q[idx_q] : '0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        HREADYOUT = 1'b1;
        HRESP     = OKAY;
        case (state_q)
            ST_IDLE: begin
                pend_d = 1'b0;
                if (take) begin
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else begin
                        pend_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d = ST_WAIT;
                            cnt_d   = CW'(WAIT_STATES);
                        end
                    end
                end
            end
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt_q <= CW'(1)) state_d = ST_IDLE;
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP   = ERROR;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            write_q <= 1'b0;
            idx_q   <= '0;
            lanes_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            // Commit precedes capture, so a pipelined next transfer sees the old registers here.
            if (complete && write_q) begin
                for (int b = 0; b < 4; b++)
                    if (lanes_q[b]) mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
            if (take) begin
                write_q <= HWRITE;
                idx_q   <= HADDR[IW+1:2];
                lanes_q <= lane_en;
            end
        end
    end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench: WAIT_STATES=1 instance driven from a vector table, WAIT_STATES=0 instance for pipelining.
module tb_ahb_slave_mem;
    import Definitions::*;

    typedef struct {
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    localparam int NV = 22;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        sel1, sel0;
    logic [31:0] HADDR, HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] rd1, rd0;
    logic        rdy1, rdy0;
    Response_t   resp1, resp0;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t tv [NV];

    logic        p_wr   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] p_addr [6] = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'h8};
    logic [31:0] p_wd   [6] = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0};
    logic [31:0] p_rd   [6] = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd3};

    always #5 HCLK = ~HCLK;

    ahb_slave_mem #(.DEPTH(64), .WAIT_STATES(1)) u_dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel1), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HREADY(rdy1),
        .HRDATA(rd1), .HREADYOUT(rdy1), .HRESP(resp1)
    );

    ahb_slave_mem #(.DEPTH(64), .WAIT_STATES(0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel0), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HREADY(rdy0),
        .HRDATA(rd0), .HREADYOUT(rdy0), .HRESP(resp0)
    );

    function automatic vec_t mk(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] er, input logic e);
        vec_t v;
        v.wr = wr; v.sz = sz; v.addr = a; v.wd = wd; v.exp_rd = er; v.exp_err = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bus_idle();
        sel1 = 1'b0; sel0 = 1'b0; HTRANS = IDLE; HWRITE = 1'b0; HSIZE = WORD; HADDR = '0;
    endtask

    // One non-pipelined transfer on the WAIT_STATES=1 slave.
    task automatic xfer1(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err,
                         output int waits, output logic done);
        sel1 = 1'b1; HTRANS = NONSEQ; HADDR = a; HWRITE = wr; HSIZE = sz;
        @(posedge HCLK); #1;
        sel1 = 1'b0; HTRANS = IDLE; HWDATA = wd;
        rd = '0; err = 1'b0; waits = 0; done = 1'b0;
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge HCLK);
            if (resp1 == ERROR) err = 1'b1;
            if (rdy1) begin rd = rd1; done = 1'b1; end
            else waits++;
        end
        @(posedge HCLK); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err, done;
        int          waits;

        tv[0]  = mk(1, WORD,   32'h10,  32'hDEADBEEF, 32'h0,        0);
        tv[1]  = mk(0, WORD,   32'h10,  32'h0,        32'hDEADBEEF, 0);
        tv[2]  = mk(1, WORD,   32'h10,  32'h11223344, 32'h0,        0);
        tv[3]  = mk(1, BYTE,   32'h13,  32'hAA000000, 32'h0,        0);
        tv[4]  = mk(0, WORD,   32'h10,  32'h0,        32'hAA223344, 0);
        tv[5]  = mk(1, HALF,   32'h12,  32'h55660000, 32'h0,        0);
        tv[6]  = mk(0, WORD,   32'h10,  32'h0,        32'h55663344, 0);
        tv[7]  = mk(1, HALF,   32'h10,  32'h00007788, 32'h0,        0);
        tv[8]  = mk(0, WORD,   32'h10,  32'h0,        32'h55667788, 0);
        tv[9]  = mk(0, WORD,   32'h100, 32'h0,        32'h0,        1);
        tv[10] = mk(1, WORD,   32'h00,  32'h12345678, 32'h0,        0);
        tv[11] = mk(1, WORD,   32'h02,  32'hFFFFFFFF, 32'h0,        1);
        tv[12] = mk(0, WORD,   32'h00,  32'h0,        32'h12345678, 0);
        tv[13] = mk(1, HALF,   32'h01,  32'h0000FFFF, 32'h0,        1);
        tv[14] = mk(0, 3'd3,   32'h04,  32'h0,        32'h0,        1);
        tv[15] = mk(1, BYTE,   32'h04,  32'h000000CC, 32'h0,        0);
        tv[16] = mk(0, WORD,   32'h04,  32'h0,        32'h000000CC, 0);
        tv[17] = mk(0, BYTE,   32'h13,  32'h0,        32'h55667788, 0);
        tv[18] = mk(1, WORD,   32'hFC,  32'hCAFEF00D, 32'h0,        0);
        tv[19] = mk(0, WORD,   32'hFC,  32'h0,        32'hCAFEF00D, 0);
        tv[20] = mk(1, WORD,   32'h100, 32'h11111111, 32'h0,        1);
        tv[21] = mk(0, HALF,   32'h12,  32'h0,        32'h55667788, 0);

        HRESETn = 1'b0; HWDATA = '0;
        bus_idle();
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(negedge HCLK);
        chk("rst rdy1",  {31'b0, rdy1}, 32'd1);
        chk("rst resp1", {31'b0, resp1}, 32'd0);
        chk("rst rd1",   rd1, 32'h0);
        chk("rst rdy0",  {31'b0, rdy0}, 32'd1);
        chk("rst rd0",   rd0, 32'h0);
        @(posedge HCLK); #1;

        for (int i = 0; i < NV; i++) begin
            xfer1(tv[i].wr, tv[i].sz, tv[i].addr, tv[i].wd, rd, err, waits, done);
            chk($sformatf("v%0d done", i),  {31'b0, done}, 32'd1);
            chk($sformatf("v%0d err", i),   {31'b0, err}, {31'b0, tv[i].exp_err});
            chk($sformatf("v%0d waits", i), waits, 32'd1);
            chk($sformatf("v%0d rdata", i), rd, tv[i].exp_rd);
        end

        // Selected but IDLE/BUSY: no access, ready and OKAY.
        sel1 = 1'b1; HTRANS = IDLE; HWRITE = 1'b1; HSIZE = WORD; HADDR = 32'h10;
        @(posedge HCLK); #1;
        HTRANS = BUSY; HWDATA = 32'hFFFFFFFF;
        @(negedge HCLK);
        chk("idle rdy",  {31'b0, rdy1}, 32'd1);
        chk("idle resp", {31'b0, resp1}, 32'd0);
        @(posedge HCLK); #1;
        bus_idle();
        @(negedge HCLK);
        chk("busy rdy",  {31'b0, rdy1}, 32'd1);
        @(posedge HCLK); #1;
        xfer1(1'b0, WORD, 32'h10, 32'h0, rd, err, waits, done);
        chk("idle untouched", rd, 32'h55667788);

        // Back-to-back pipelined transfers with zero wait states.
        for (int s = 0; s <= 6; s++) begin
            if (s < 6) begin
                sel0 = 1'b1; HTRANS = NONSEQ; HWRITE = p_wr[s]; HADDR = p_addr[s]; HSIZE = WORD;
            end else begin
                sel0 = 1'b0; HTRANS = IDLE;
            end
            HWDATA = (s > 0) ? p_wd[s-1] : 32'h0;
            @(negedge HCLK);
            if (s > 0) begin
                chk($sformatf("pipe%0d rdy", s),   {31'b0, rdy0}, 32'd1);
                chk($sformatf("pipe%0d rdata", s), rd0, p_rd[s-1]);
                chk($sformatf("pipe%0d resp", s),  {31'b0, resp0}, 32'd0);
            end
            @(posedge HCLK); #1;
        end

        // Reset while the write sits in its wait state.
        sel1 = 1'b1; HTRANS = NONSEQ; HADDR = 32'h20; HWRITE = 1'b1; HSIZE = WORD;
        @(posedge HCLK); #1;
        sel1 = 1'b0; HTRANS = IDLE; HWDATA = 32'h55;
        @(negedge HCLK);
        chk("wait rdy", {31'b0, rdy1}, 32'd0);
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("mid rst rdy",  {31'b0, rdy1}, 32'd1);
        chk("mid rst resp", {31'b0, resp1}, 32'd0);
        chk("mid rst rd",   rd1, 32'h0);
        @(posedge HCLK); #1;
        xfer1(1'b0, WORD, 32'h20, 32'h0, rd, err, waits, done);
        chk("rst 0x20", rd, 32'h0);
        xfer1(1'b0, WORD, 32'h10, 32'h0, rd, err, waits, done);
        chk("rst 0x10", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
